// File: rtl/mem_ctrl_pkg.sv
// Shared constants for the byte-serial memory controller: datapath widths,
// MEM access length encodings and the requester identity type.
package mem_ctrl_pkg;

  localparam int AddrLen    = 32;
  localparam int InstLen    = 32;
  localparam int RegLen     = 32;
  localparam int RamDataLen = 8;

  localparam logic [1:0] MemLenByte = 2'b00;
  localparam logic [1:0] MemLenHalf = 2'b01;
  localparam logic [1:0] MemLenWord = 2'b10;

  typedef enum logic {
    REQ_IF  = 1'b0,
    REQ_MEM = 1'b1
  } requester_e;

  // Number of bytes moved for a MEM length code; the reserved code 11 is a word.
  function automatic logic [2:0] len_bytes(input logic [1:0] len);
    case (len)
      MemLenByte: len_bytes = 3'd1;
      MemLenHalf: len_bytes = 3'd2;
      default:    len_bytes = 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/mem_ctrl.sv
// Shares one 8-bit RAM port between instruction fetch and the load/store
// stage. Transfers run one byte per cycle, little-endian, and finish with a
// single DONE cycle in which the owner's done output is high.
module mem_ctrl
  import mem_ctrl_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  if_req,
  input  logic [AddrLen-1:0]    if_addr,
  output logic                  if_done,
  output logic [InstLen-1:0]    if_inst,
  input  logic                  jump_or_not,
  input  logic                  mem_req,
  input  logic                  mem_we,
  input  logic [1:0]            mem_len,
  input  logic [AddrLen-1:0]    mem_addr,
  input  logic [RegLen-1:0]     mem_wdata,
  output logic                  mem_done,
  output logic [RegLen-1:0]     mem_rdata,
  output logic [AddrLen-1:0]    ram_addr,
  output logic                  ram_wr,
  output logic [RamDataLen-1:0] ram_dout,
  input  logic [RamDataLen-1:0] ram_din
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    IF_RD  = 3'd1,
    MEM_RD = 3'd2,
    MEM_WR = 3'd3,
    DONE   = 3'd4
  } state_e;

  state_e               state_q, state_d;
  logic [2:0]           cnt_q, cnt_d;
  logic [2:0]           len_q, len_d;
  logic [AddrLen-1:0]   base_q, base_d;
  logic [RegLen-1:0]    wdata_q, wdata_d;
  logic [RegLen-1:0]    rbuf_q, rbuf_d;
  requester_e           owner_q, owner_d;
  logic [AddrLen-1:0]   ram_addr_d;
  logic                 ram_wr_d;
  logic [RamDataLen-1:0] ram_dout_d;
  logic [InstLen-1:0]   if_inst_d;
  logic [RegLen-1:0]    mem_rdata_d;
  logic [RegLen-1:0]    assembled;
  logic [1:0]           cap_idx;
  logic                 take_mem, take_if;
  logic                 done_r;

  // The done cycle is decoded straight from the state; a fetch finishing
  // while a jump is taken is swallowed here.
  assign done_r   = (state_q == DONE);
  assign if_done  = done_r && (owner_q == REQ_IF) && !jump_or_not;
  assign mem_done = done_r && (owner_q == REQ_MEM);

  // Register every piece of controller state and every RAM-facing output.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      len_q     <= '0;
      base_q    <= '0;
      wdata_q   <= '0;
      rbuf_q    <= '0;
      owner_q   <= REQ_IF;
      ram_addr  <= '0;
      ram_wr    <= 1'b0;
      ram_dout  <= '0;
      if_inst   <= '0;
      mem_rdata <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      len_q     <= len_d;
      base_q    <= base_d;
      wdata_q   <= wdata_d;
      rbuf_q    <= rbuf_d;
      owner_q   <= owner_d;
      ram_addr  <= ram_addr_d;
      ram_wr    <= ram_wr_d;
      ram_dout  <= ram_dout_d;
      if_inst   <= if_inst_d;
      mem_rdata <= mem_rdata_d;
    end
  end

  // Next-state logic: arbitration, address/byte sequencing and word assembly.
  // cnt holds the transfer cycle number, so the byte arriving now is cnt-2.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    len_d       = len_q;
    base_d      = base_q;
    wdata_d     = wdata_q;
    rbuf_d      = rbuf_q;
    owner_d     = owner_q;
    ram_addr_d  = ram_addr;
    ram_wr_d    = 1'b0;
    ram_dout_d  = '0;
    if_inst_d   = if_inst;
    mem_rdata_d = mem_rdata;
    take_mem    = 1'b0;
    take_if     = 1'b0;

    cap_idx   = cnt_q[1:0] - 2'd2;
    assembled = rbuf_q;
    assembled[{cap_idx, 3'b000} +: 8] = ram_din;

    case (state_q)
      IDLE: begin
        ram_addr_d = '0;
        take_mem   = mem_req;
        take_if    = !mem_req && if_req && !jump_or_not;
      end

      IF_RD, MEM_RD: begin
        if ((state_q == IF_RD) && jump_or_not) begin
          state_d    = IDLE;
          cnt_d      = '0;
          rbuf_d     = '0;
          ram_addr_d = '0;
        end else begin
          cnt_d      = cnt_q + 3'd1;
          ram_addr_d = (cnt_q < len_q) ? base_q + {29'd0, cnt_q} : '0;
          if (cnt_q >= 3'd2) begin
            rbuf_d = assembled;
          end
          if (cnt_q == len_q + 3'd1) begin
            state_d    = DONE;
            cnt_d      = '0;
            ram_addr_d = '0;
            if (owner_q == REQ_IF) begin
              if_inst_d = assembled;
            end else begin
              mem_rdata_d = assembled;
            end
          end
        end
      end

      MEM_WR: begin
        if (cnt_q < len_q) begin
          ram_wr_d   = 1'b1;
          ram_addr_d = base_q + {29'd0, cnt_q};
          ram_dout_d = wdata_q[{cnt_q[1:0], 3'b000} +: 8];
          cnt_d      = cnt_q + 3'd1;
        end else begin
          state_d    = DONE;
          cnt_d      = '0;
          ram_addr_d = '0;
        end
      end

      DONE: begin
        state_d    = IDLE;
        ram_addr_d = '0;
        take_mem   = (owner_q == REQ_IF) && mem_req;
        take_if    = (owner_q == REQ_MEM) && if_req && !jump_or_not;
      end

      default: begin
        state_d    = IDLE;
        cnt_d      = '0;
        ram_addr_d = '0;
      end
    endcase

    if (take_mem) begin
      owner_d    = REQ_MEM;
      base_d     = mem_addr;
      len_d      = len_bytes(mem_len);
      wdata_d    = mem_wdata;
      rbuf_d     = '0;
      cnt_d      = 3'd1;
      ram_addr_d = mem_addr;
      if (mem_we) begin
        state_d    = MEM_WR;
        ram_wr_d   = 1'b1;
        ram_dout_d = mem_wdata[7:0];
      end else begin
        state_d = MEM_RD;
      end
    end else if (take_if) begin
      owner_d    = REQ_IF;
      base_d     = if_addr;
      len_d      = 3'd4;
      rbuf_d     = '0;
      cnt_d      = 3'd1;
      ram_addr_d = if_addr;
      state_d    = IF_RD;
    end
  end

endmodule
